// File: rtl/tiny86_pkg.sv
// Shared tiny86 definitions: x86 register encoding and destination write sizes.
package tiny86_pkg;

    localparam int GPR_COUNT = 8;

    localparam logic [2:0] REG_EAX = 3'd0;
    localparam logic [2:0] REG_ECX = 3'd1;
    localparam logic [2:0] REG_EDX = 3'd2;
    localparam logic [2:0] REG_EBX = 3'd3;
    localparam logic [2:0] REG_ESP = 3'd4;
    localparam logic [2:0] REG_EBP = 3'd5;
    localparam logic [2:0] REG_ESI = 3'd6;
    localparam logic [2:0] REG_EDI = 3'd7;

    typedef enum logic [1:0] {
        SZ_R8L = 2'd0,
        SZ_R8H = 2'd1,
        SZ_R16 = 2'd2,
        SZ_R32 = 2'd3
    } wr_size_t;

endpackage

// File: rtl/gpr_merge.sv
// Per-register next-value merge: overlays the destination write lane onto the
// (optionally ESP-adjusted) current value and reports which bytes were written.
module gpr_merge
    import tiny86_pkg::*;
(
    input  logic [2:0]  reg_idx,
    input  logic [31:0] old_val,
    input  logic [31:0] adj_val,
    input  logic        adj_en,
    input  logic        wr_en,
    input  logic [1:0]  wr_size,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] next_val,
    output logic [3:0]  byte_mask
);

    logic [31:0] lane;
    logic [31:0] base;

    always_comb begin
        byte_mask = 4'b0000;
        lane      = wr_data;
        base      = adj_en ? adj_val : old_val;
        if (wr_en) begin
            case (wr_size_t'(wr_size))
                SZ_R8L, SZ_R8H: begin
                    // r8 encodings 4..7 name the high byte of registers 0..3
                    lane = {4{wr_data[7:0]}};
                    if (!wr_sel[2] && (wr_sel == reg_idx))
                        byte_mask = 4'b0001;
                    else if (wr_sel[2] && ({1'b0, wr_sel[1:0]} == reg_idx))
                        byte_mask = 4'b0010;
                end
                SZ_R16: if (wr_sel == reg_idx) byte_mask = 4'b0011;
                SZ_R32: if (wr_sel == reg_idx) byte_mask = 4'b1111;
                default: byte_mask = 4'b0000;
            endcase
        end
        for (int b = 0; b < 4; b++)
            next_val[8*b +: 8] = byte_mask[b] ? lane[8*b +: 8] : base[8*b +: 8];
    end

endmodule

// File: rtl/gpr_file.sv
// tiny86 architectural register file: eight 32-bit GPRs with sub-register
// destination writes, an ESP adjust port and a written-since-clear mask.
module gpr_file
    import tiny86_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         init_en,
    input  logic [255:0] init_regs,
    input  logic         wr_en,
    input  logic [2:0]   wr_sel,
    input  logic [1:0]   wr_size,
    input  logic [31:0]  wr_data,
    input  logic         esp_en,
    input  logic [31:0]  esp_delta,
    input  logic         dirty_clr,
    output logic [31:0]  gpr0,
    output logic [31:0]  gpr1,
    output logic [31:0]  gpr2,
    output logic [31:0]  gpr3,
    output logic [31:0]  gpr4,
    output logic [31:0]  gpr5,
    output logic [31:0]  gpr6,
    output logic [31:0]  gpr7,
    output logic [7:0]   dirty
);

    logic [31:0] regs     [GPR_COUNT];
    logic [31:0] next_val [GPR_COUNT];
    logic [3:0]  mask     [GPR_COUNT];
    logic [31:0] esp_adj;
    logic [7:0]  dirty_set;

    assign esp_adj = regs[REG_ESP] + esp_delta;

    for (genvar i = 0; i < GPR_COUNT; i++) begin : g_merge
        gpr_merge u_merge (
            .reg_idx   (3'(i)),
            .old_val   (regs[i]),
            .adj_val   (esp_adj),
            .adj_en    ((i == int'(REG_ESP)) ? esp_en : 1'b0),
            .wr_en     (wr_en),
            .wr_size   (wr_size),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data),
            .next_val  (next_val[i]),
            .byte_mask (mask[i])
        );
    end

    always_comb begin
        dirty_set = 8'h00;
        for (int i = 0; i < GPR_COUNT; i++)
            dirty_set[i] = |mask[i];
        dirty_set[REG_ESP] = dirty_set[REG_ESP] | esp_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GPR_COUNT; i++)
                regs[i] <= '0;
            dirty <= 8'h00;
        end else if (init_en) begin
            for (int i = 0; i < GPR_COUNT; i++)
                regs[i] <= init_regs[32*i +: 32];
            dirty <= 8'h00;
        end else begin
            for (int i = 0; i < GPR_COUNT; i++)
                regs[i] <= next_val[i];
            // clear first so bits set by this cycle's writes survive
            dirty <= (dirty_clr ? 8'h00 : dirty) | dirty_set;
        end
    end

    assign gpr0 = regs[REG_EAX];
    assign gpr1 = regs[REG_ECX];
    assign gpr2 = regs[REG_EDX];
    assign gpr3 = regs[REG_EBX];
    assign gpr4 = regs[REG_ESP];
    assign gpr5 = regs[REG_EBP];
    assign gpr6 = regs[REG_ESI];
    assign gpr7 = regs[REG_EDI];

endmodule
